data_ram_copier: RTL

DATA_RAM_COPIER -- requirements
Module: data_ram_copier

---
 rtl/data_ram_copier.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_ram_copier.sv
// Word-by-word RAM copy engine: READ latches one source word, WRITE stores it at the destination.
// Optional fill mode (writes a constant, no reads) is enabled with `define DATA_RAM_COPIER_FILL_EN.
module data_ram_copier #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddress,
  input  logic [ADDR_WIDTH-1:0] dstAddress,
  input  logic [ADDR_WIDTH-1:0] length,
`ifdef DATA_RAM_COPIER_FILL_EN
  input  logic                  fillMode,
  input  logic [DATA_WIDTH-1:0] fillValue,
`endif
  input  logic [DATA_WIDTH-1:0] dataRAMOutput,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] dataC
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] fill_value_q, fill_value_d;
  logic                  fill_in;
  logic [DATA_WIDTH-1:0] fill_value_in;
  logic [ADDR_WIDTH-1:0] index_inc;

`ifdef DATA_RAM_COPIER_FILL_EN
  assign fill_in       = fillMode;
  assign fill_value_in = fillValue;
`else
  assign fill_in       = 1'b0;
  assign fill_value_in = '0;
`endif

  assign index_inc = index_q + ADDR_WIDTH'(1);

  // NOTE: every output and next-state signal gets a default before the case, so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    hold_d       = hold_q;
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    busy         = 1'b0;
    done         = 1'b0;
    address      = '0;
    writeEnable  = 1'b0;
    dataC        = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = srcAddress;
          dst_d        = dstAddress;
          len_d        = length;
          fill_d       = fill_in;
          fill_value_d = fill_value_in;
          index_d      = '0;
          if (length == '0)  state_d = DONE;
          else if (fill_in)  state_d = WRITE;
          else               state_d = READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        address = src_q + index_q;
        hold_d  = dataRAMOutput;
        state_d = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        address     = dst_q + index_q;
        writeEnable = 1'b1;
        dataC       = fill_q ? fill_value_q : hold_q;
        index_d     = index_inc;
        if (index_inc == len_q) state_d = DONE;
        else if (fill_q)        state_d = WRITE;
        else                    state_d = READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      hold_q       <= '0;
      fill_q       <= 1'b0;
      fill_value_q <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
    end
  end

endmodule
